// File: rtl/regfile_scoreboard.sv
// 64-entry integer/float register file with a per-register busy scoreboard.
// Combinational write-first reads and RAW/WAW issue-hazard detection.
module regfile_scoreboard #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NRD  = 3,
  parameter int unsigned NWB  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*6-1:0]    rs,
  input  logic [NRD-1:0]      rs_en,
  output logic [NRD*XLEN-1:0] rsdata,
  input  logic [NWB*7-1:0]    wb_rd,
  input  logic [NWB*XLEN-1:0] wb_data,
  input  logic [6:0]          issue_rd,
  input  logic                issue_valid,
  output logic                hazard,
  output logic [63:0]         busy_o
);

  localparam int unsigned NReg = 64;

  logic [XLEN-1:0] data_q [NReg];
  logic [XLEN-1:0] data_d [NReg];
  logic [NReg-1:0] busy_q, busy_d;
  logic [NReg-1:0] clearing, pending;
  logic            raw, waw, issue_fire;

  // Write-first read: later wb ports override earlier ones, index 0 is hardwired.
  always_comb begin
    rsdata = '0;
    for (int k = 0; k < NRD; k++) begin
      if (rs[6*k +: 6] != 6'd0) begin
        rsdata[XLEN*k +: XLEN] = data_q[rs[6*k +: 6]];
        for (int j = 0; j < NWB; j++) begin
          if (wb_rd[7*j+6] && (wb_rd[7*j +: 6] == rs[6*k +: 6])) begin
            rsdata[XLEN*k +: XLEN] = wb_data[XLEN*j +: XLEN];
          end
        end
      end
    end
  end

  always_comb begin
    clearing = '0;
    for (int j = 0; j < NWB; j++) begin
      if (wb_rd[7*j+6]) clearing[wb_rd[7*j +: 6]] = 1'b1;
    end
  end

  assign pending = busy_q & ~clearing;

  always_comb begin
    raw = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      if (rs_en[k] && pending[rs[6*k +: 6]]) raw = 1'b1;
    end
  end

  assign waw        = issue_rd[6] && pending[issue_rd[5:0]];
  assign hazard     = issue_valid && (raw || waw);
  assign issue_fire = issue_valid && !hazard;
  assign busy_o     = busy_q;

  always_comb begin
    for (int i = 0; i < NReg; i++) data_d[i] = data_q[i];
    for (int j = 0; j < NWB; j++) begin
      if (wb_rd[7*j+6] && (wb_rd[7*j +: 6] != 6'd0)) begin
        data_d[wb_rd[7*j +: 6]] = wb_data[XLEN*j +: XLEN];
      end
    end
  end

  // Set is applied after clear so a same-cycle issue keeps the bit high.
  always_comb begin
    busy_d = busy_q & ~clearing;
    if (issue_fire && issue_rd[6]) busy_d[issue_rd[5:0]] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      for (int i = 0; i < NReg; i++) data_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < NReg; i++) data_q[i] <= data_d[i];
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed-vector bench for regfile_scoreboard with hand-computed expectations.
module tb_regfile_scoreboard;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NRD  = 3;
  localparam int unsigned NWB  = 2;

  logic                clk;
  logic                rst;
  logic [NRD*6-1:0]    rs;
  logic [NRD-1:0]      rs_en;
  logic [NRD*XLEN-1:0] rsdata;
  logic [NWB*7-1:0]    wb_rd;
  logic [NWB*XLEN-1:0] wb_data;
  logic [6:0]          issue_rd;
  logic                issue_valid;
  logic                hazard;
  logic [63:0]         busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_scoreboard #(
    .XLEN(XLEN),
    .NRD (NRD),
    .NWB (NWB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rs         (rs),
    .rs_en      (rs_en),
    .rsdata     (rsdata),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .issue_rd   (issue_rd),
    .issue_valid(issue_valid),
    .hazard     (hazard),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs          = '0;
    rs_en       = '0;
    wb_rd       = '0;
    wb_data     = '0;
    issue_rd    = '0;
    issue_valid = 1'b0;
  endtask

  task automatic set_rs(input int k, input logic [5:0] idx, input logic en);
    rs[6*k +: 6] = idx;
    rs_en[k]     = en;
  endtask

  task automatic set_wb(input int j, input logic [5:0] idx, input logic [31:0] d);
    wb_rd[7*j +: 7]         = {1'b1, idx};
    wb_data[XLEN*j +: XLEN] = d;
  endtask

  task automatic issue(input logic [5:0] idx);
    issue_valid = 1'b1;
    issue_rd    = {1'b1, idx};
  endtask

  // Advance to just after the next rising edge with all inputs idle.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  function automatic logic [31:0] rd_port(input int k);
    return rsdata[XLEN*k +: XLEN];
  endfunction

  initial begin
    idle();
    rst = 1'b0;
    #12;
    set_rs(0, 6'd5, 1'b1);
    #1;
    check("reset_busy", busy_o, 64'h0);
    check("reset_hazard", {63'h0, hazard}, 64'h0);
    check("reset_read", rd_port(0), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Bypass then stored read of x5.
    step();
    set_wb(0, 6'd5, 32'hDEADBEEF);
    set_rs(0, 6'd5, 1'b1);
    #1;
    check("x5_bypass", rd_port(0), 32'hDEADBEEF);
    step();
    set_rs(0, 6'd5, 1'b1);
    #1;
    check("x5_stored", rd_port(0), 32'hDEADBEEF);

    // Two ports write x7: port 1 wins.
    step();
    set_wb(0, 6'd7, 32'h1);
    set_wb(1, 6'd7, 32'h2);
    set_rs(1, 6'd7, 1'b1);
    #1;
    check("x7_bypass_prio", rd_port(1), 32'h2);
    step();
    set_rs(1, 6'd7, 1'b1);
    #1;
    check("x7_stored_prio", rd_port(1), 32'h2);

    // Writes to x0 are dropped.
    step();
    set_wb(0, 6'd0, 32'hFFFF);
    set_rs(2, 6'd0, 1'b1);
    #1;
    check("x0_bypass", rd_port(2), 32'h0);
    step();
    set_rs(2, 6'd0, 1'b1);
    #1;
    check("x0_stored", rd_port(2), 32'h0);

    // RAW on f3 (index 35), resolved by same-cycle write-back.
    step();
    issue(6'd35);
    #1;
    check("f3_issue_hz", {63'h0, hazard}, 64'h0);
    step();
    check("f3_busy_set", {63'h0, busy_o[35]}, 64'h1);
    issue_valid = 1'b1;
    set_rs(0, 6'd35, 1'b1);
    #1;
    check("f3_raw_hz", {63'h0, hazard}, 64'h1);
    set_wb(0, 6'd35, 32'h3F800000);
    #1;
    check("f3_raw_clear_hz", {63'h0, hazard}, 64'h0);
    check("f3_raw_bypass", rd_port(0), 32'h3F800000);
    step();
    check("f3_busy_cleared", {63'h0, busy_o[35]}, 64'h0);

    // Set wins over clear on x10.
    issue(6'd10);
    #1;
    step();
    check("x10_busy_set", {63'h0, busy_o[10]}, 64'h1);
    set_wb(1, 6'd10, 32'hAA);
    issue(6'd10);
    #1;
    check("x10_setclr_hz", {63'h0, hazard}, 64'h0);
    step();
    set_rs(0, 6'd10, 1'b1);
    #1;
    check("x10_set_wins", {63'h0, busy_o[10]}, 64'h1);
    check("x10_data", rd_port(0), 32'hAA);

    // WAW on x12, source-enable gating, issue_valid gating.
    step();
    issue(6'd12);
    #1;
    step();
    issue(6'd12);
    #1;
    check("x12_waw_hz", {63'h0, hazard}, 64'h1);
    issue_rd = 7'h0;
    set_rs(1, 6'd12, 1'b0);
    #1;
    check("x12_rs_dis_hz", {63'h0, hazard}, 64'h0);
    set_rs(1, 6'd12, 1'b1);
    #1;
    check("x12_raw_hz", {63'h0, hazard}, 64'h1);
    issue_valid = 1'b0;
    #1;
    check("x12_novalid_hz", {63'h0, hazard}, 64'h0);

    // Write-back to a non-busy register.
    step();
    set_wb(0, 6'd20, 32'h1234);
    #1;
    step();
    set_rs(0, 6'd20, 1'b1);
    #1;
    check("x20_busy", {63'h0, busy_o[20]}, 64'h0);
    check("x20_data", rd_port(0), 32'h1234);
    check("busy_vector", busy_o, (64'h1 << 10) | (64'h1 << 12));

    // Asynchronous reset mid-operation.
    step();
    issue(6'd3);
    set_wb(0, 6'd4, 32'h55);
    #1;
    step();
    set_rs(0, 6'd4, 1'b1);
    #1;
    check("x3_busy_pre", {63'h0, busy_o[3]}, 64'h1);
    check("x4_pre", rd_port(0), 32'h55);
    rst = 1'b0;
    #1;
    check("rst_busy_async", busy_o, 64'h0);
    check("rst_x4_async", rd_port(0), 32'h0);
    set_wb(1, 6'd9, 32'h99);
    set_rs(1, 6'd9, 1'b1);
    issue(6'd9);
    #1;
    check("rst_bypass", rd_port(1), 32'h99);
    check("rst_hazard", {63'h0, hazard}, 64'h0);
    @(posedge clk);
    #1;
    check("rst_no_issue", busy_o, 64'h0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    step();
    set_rs(0, 6'd9, 1'b1);
    set_rs(1, 6'd10, 1'b1);
    set_rs(2, 6'd5, 1'b1);
    issue_valid = 1'b1;
    #1;
    check("post_x9", rd_port(0), 32'h0);
    check("post_x10", rd_port(1), 32'h0);
    check("post_x5", rd_port(2), 32'h0);
    check("post_busy", busy_o, 64'h0);
    check("post_hazard", {63'h0, hazard}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
